// File: rtl/vreg_file.sv
// Vector register file: two registered read ports, one element-masked write port,
// a per-register busy scoreboard and a sequenced clear-all sweep.
// Optional feature macro: VREG_BYPASS_EN forwards a same-cycle accepted write to the read ports.
module vreg_file #(
    parameter  int VLEN = 256,
    parameter  int NREG = 8,
    parameter  int ELEN = 32,
    localparam int AW   = $clog2(NREG),
    localparam int NE   = VLEN / ELEN
) (
    input  logic            RST,
    input  logic            CLK_DC,
    input  logic            RE,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic            WE,
    input  logic [AW-1:0]   A3,
    input  logic [VLEN-1:0] WB,
    input  logic [NE-1:0]   WMASK,
    input  logic            ISS_EN,
    input  logic [AW-1:0]   ISS_RD,
    input  logic            CLR_REQ,
    output logic [VLEN-1:0] RD1,
    output logic [VLEN-1:0] RD2,
    output logic            RD1_BUSY,
    output logic            RD2_BUSY,
    output logic            CLR_BUSY
);

    // Request semantics: WE and ISS_EN are single-cycle strobes with no back-pressure.
    // They are accepted on any rising edge where CLR_BUSY is low and silently dropped
    // while it is high; CLR_REQ is only honoured while CLR_BUSY is low.

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   idx, idx_nxt;

    logic [VLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    logic            wr_acc;
    logic            iss_acc;
    logic [VLEN-1:0] merged_wr;
    logic [VLEN-1:0] rd1_nxt, rd2_nxt;
    logic            rd1_busy_nxt, rd2_busy_nxt;

    // CLR_BUSY is the FSM state bit itself, so it doubles as the state debug view.
    assign CLR_BUSY = (state == SWEEP);
    assign wr_acc   = WE && (state == IDLE);
    assign iss_acc  = ISS_EN && (state == IDLE);

    always_comb begin
        merged_wr = regs[A3];
        for (int e = 0; e < NE; e++) begin
            if (WMASK[e]) begin
                merged_wr[e*ELEN +: ELEN] = WB[e*ELEN +: ELEN];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (CLR_REQ) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                end
            end
            SWEEP: begin
                idx_nxt = idx + AW'(1);
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (state == SWEEP) begin
            regs[idx] <= '0;
        end else if (wr_acc) begin
            regs[A3] <= merged_wr;
        end
    end

    // The issue update comes after the write clear so a same-register issue wins.
    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            busy <= '0;
        end else if (state == SWEEP) begin
            busy[idx] <= 1'b0;
        end else begin
            if (wr_acc) begin
                busy[A3] <= 1'b0;
            end
            if (iss_acc) begin
                busy[ISS_RD] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd1_nxt      = regs[A1];
        rd2_nxt      = regs[A2];
        rd1_busy_nxt = busy[A1];
        rd2_busy_nxt = busy[A2];
`ifdef VREG_BYPASS_EN
        if (wr_acc && (A1 == A3)) begin
            rd1_nxt      = merged_wr;
            rd1_busy_nxt = iss_acc && (ISS_RD == A1);
        end
        if (wr_acc && (A2 == A3)) begin
            rd2_nxt      = merged_wr;
            rd2_busy_nxt = iss_acc && (ISS_RD == A2);
        end
`endif
    end

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            RD1      <= '0;
            RD2      <= '0;
            RD1_BUSY <= 1'b0;
            RD2_BUSY <= 1'b0;
        end else if (RE) begin
            RD1      <= rd1_nxt;
            RD2      <= rd2_nxt;
            RD1_BUSY <= rd1_busy_nxt;
            RD2_BUSY <= rd2_busy_nxt;
        end
    end

endmodule

// File: tb/tb_vreg_file.sv
// Randomized and directed bench for vreg_file against an array-based reference model.
// Honours VREG_BYPASS_EN the same way the design does.
module tb_vreg_file;
    localparam int VLEN = 256;
    localparam int NREG = 8;
    localparam int ELEN = 32;
    localparam int AW   = 3;
    localparam int NE   = 8;

    logic            RST;
    logic            CLK_DC = 1'b0;
    logic            RE, WE, ISS_EN, CLR_REQ;
    logic [AW-1:0]   A1, A2, A3, ISS_RD;
    logic [VLEN-1:0] WB;
    logic [NE-1:0]   WMASK;
    logic [VLEN-1:0] RD1, RD2;
    logic            RD1_BUSY, RD2_BUSY, CLR_BUSY;

    vreg_file #(.VLEN(VLEN), .NREG(NREG), .ELEN(ELEN)) dut (
        .RST(RST), .CLK_DC(CLK_DC), .RE(RE), .A1(A1), .A2(A2), .WE(WE), .A3(A3),
        .WB(WB), .WMASK(WMASK), .ISS_EN(ISS_EN), .ISS_RD(ISS_RD), .CLR_REQ(CLR_REQ),
        .RD1(RD1), .RD2(RD2), .RD1_BUSY(RD1_BUSY), .RD2_BUSY(RD2_BUSY), .CLR_BUSY(CLR_BUSY)
    );

    always #5 CLK_DC = ~CLK_DC;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays plus a count of sweep cycles still to run.
    logic [VLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];
    int              m_left;
    logic [VLEN-1:0] e_rd1, e_rd2;
    logic            e_b1, e_b2;

    task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("rd1", RD1, e_rd1);
        chk("rd2", RD2, e_rd2);
        chk("rd1_busy", VLEN'(RD1_BUSY), VLEN'(e_b1));
        chk("rd2_busy", VLEN'(RD2_BUSY), VLEN'(e_b2));
        chk("clr_busy", VLEN'(CLR_BUSY), VLEN'(m_left > 0));
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        m_left = 0;
        e_rd1  = '0;
        e_rd2  = '0;
        e_b1   = 1'b0;
        e_b2   = 1'b0;
    endtask

    // Advance the model by one edge using the inputs currently driven, then check the DUT.
    task automatic tick();
        logic [VLEN-1:0] newv;
        logic            sweeping;
        logic            acc;
        int              victim;
        sweeping = (m_left > 0);
        acc      = WE && !sweeping;
        newv     = m_regs[A3];
        for (int e = 0; e < NE; e++) begin
            if (WMASK[e]) newv[e*ELEN +: ELEN] = WB[e*ELEN +: ELEN];
        end
        if (RE) begin
            e_rd1 = m_regs[A1];
            e_rd2 = m_regs[A2];
            e_b1  = m_busy[A1];
            e_b2  = m_busy[A2];
`ifdef VREG_BYPASS_EN
            if (acc && A1 == A3) begin
                e_rd1 = newv;
                e_b1  = ISS_EN && (ISS_RD == A1);
            end
            if (acc && A2 == A3) begin
                e_rd2 = newv;
                e_b2  = ISS_EN && (ISS_RD == A2);
            end
`endif
        end
        if (sweeping) begin
            victim         = NREG - m_left;
            m_regs[victim] = '0;
            m_busy[victim] = 1'b0;
            m_left--;
        end else begin
            if (acc) begin
                m_regs[A3] = newv;
                m_busy[A3] = 1'b0;
            end
            if (ISS_EN) m_busy[ISS_RD] = 1'b1;
            if (CLR_REQ) m_left = NREG;
        end
        @(posedge CLK_DC);
        #1;
        check_all();
    endtask

    task automatic idle();
        RE = 1'b0; WE = 1'b0; ISS_EN = 1'b0; CLR_REQ = 1'b0;
    endtask

    task automatic rand_wb();
        for (int e = 0; e < NE; e++) WB[e*ELEN +: ELEN] = $urandom() | 32'h1;
    endtask

    task automatic do_write(input int a, input logic [VLEN-1:0] d, input logic [NE-1:0] m);
        idle();
        WE = 1'b1; A3 = AW'(a); WB = d; WMASK = m;
        tick();
    endtask

    task automatic do_read(input int a1, input int a2);
        idle();
        RE = 1'b1; A1 = AW'(a1); A2 = AW'(a2);
        tick();
    endtask

    task automatic fill_all();
        for (int r = 0; r < NREG; r++) begin
            idle();
            WE = 1'b1; A3 = AW'(r); WMASK = '1;
            rand_wb();
            tick();
        end
    endtask

    logic [VLEN-1:0] v4, v6, exp_byp, one_v;
    int              busy_cycles;

    initial begin
        RST = 1'b0;
        idle();
        A1 = '0; A2 = '0; A3 = '0; ISS_RD = '0; WB = '0; WMASK = '0;
        model_reset();
        #12;
        check_all();
        @(negedge CLK_DC);
        RST = 1'b1;

        // Reset in the middle of a sweep, then every register reads back zero.
        fill_all();
        idle(); CLR_REQ = 1'b1; tick();
        idle(); tick(); tick(); tick();
        #2 RST = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge CLK_DC);
        RST = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            do_read(r, r);
            chk("rst_rd", RD1, '0);
            chk("rst_busy", VLEN'(RD2_BUSY), '0);
        end

        // Masked write over an all-ones register.
        do_write(3, '1, '1);
        do_write(3, {NE{32'hA5A5A5A5}}, 8'h0F);
        do_read(3, 3);
        chk("masked_r3", RD1, {{4{32'hFFFFFFFF}}, {4{32'hA5A5A5A5}}});

        // Same-cycle write and read of r2.
        do_write(2, '0, '1);
        one_v = VLEN'(1);
        idle();
        WE = 1'b1; A3 = 3'd2; WB = one_v; WMASK = '1; RE = 1'b1; A1 = 3'd2; A2 = 3'd0;
        tick();
`ifdef VREG_BYPASS_EN
        exp_byp = one_v;
`else
        exp_byp = '0;
`endif
        chk("bypass_rd1", RD1, exp_byp);
        do_read(2, 2);
        chk("after_byp", RD1, one_v);

        // Scoreboard set, set-wins, then clear.
        idle(); ISS_EN = 1'b1; ISS_RD = 3'd5; tick();
        do_read(5, 0);
        chk("sb_issue", VLEN'(RD1_BUSY), VLEN'(1));
        idle(); ISS_EN = 1'b1; ISS_RD = 3'd5; WE = 1'b1; A3 = 3'd5; rand_wb(); WMASK = '1; tick();
        do_read(5, 0);
        chk("sb_setwins", VLEN'(RD1_BUSY), VLEN'(1));
        do_write(5, '1, 8'h00);
        do_read(0, 5);
        chk("sb_clear", VLEN'(RD2_BUSY), '0);

        // Clear sweep with a write to r1 held throughout; it must be dropped.
        fill_all();
        idle(); CLR_REQ = 1'b1; tick();
        busy_cycles = int'(CLR_BUSY);
        for (int k = 0; k < NREG; k++) begin
            idle(); WE = 1'b1; A3 = 3'd1; rand_wb(); WMASK = '1; CLR_REQ = (k == 3);
            tick();
            busy_cycles += int'(CLR_BUSY);
        end
        chk("sweep_len", VLEN'(busy_cycles), VLEN'(NREG));
        for (int r = 0; r < NREG; r++) begin
            do_read(r, r);
            chk("swept", RD1, '0);
        end

        // Read ports hold while RE is low.
        rand_wb(); v4 = WB; do_write(4, v4, '1);
        rand_wb(); v6 = WB; do_write(6, v6, '1);
        do_read(4, 6);
        idle(); A1 = 3'd6; A2 = 3'd4; tick();
        chk("hold_rd1", RD1, v4);
        chk("hold_rd2", RD2, v6);
        RE = 1'b1; tick();
        chk("swap_rd1", RD1, v6);
        chk("swap_rd2", RD2, v4);

        // Random traffic with address collisions biased in.
        for (int n = 0; n < 800; n++) begin
            RE      = 1'($urandom_range(0, 1));
            WE      = 1'($urandom_range(0, 1));
            ISS_EN  = ($urandom_range(0, 2) == 0);
            CLR_REQ = ($urandom_range(0, 49) == 0);
            A1      = AW'($urandom_range(0, NREG - 1));
            A2      = AW'($urandom_range(0, NREG - 1));
            A3      = ($urandom_range(0, 2) == 0) ? A1 : AW'($urandom_range(0, NREG - 1));
            ISS_RD  = ($urandom_range(0, 2) == 0) ? A3 : AW'($urandom_range(0, NREG - 1));
            WMASK   = NE'($urandom());
            rand_wb();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
